ascon_serial_loader: RTL and testbench
======================================

Name: ascon_serial_loader

Overview:
- Upstream front-end for the bit-serial ASCON AEAD core in the user project area, fed from the GPIO pins.
- Deserialises four parallel MSB-first serial lanes (key, nonce, associated data, input data) into parallel registers.
- Captures the encrypt/decrypt mode and issues a single-cycle start pulse to the core.
- Tracks the core until it reports ready, then accepts the next frame.

Parameters:
- K, 128, key width in bits
- NW, 128, nonce width in bits
- L, 40, associated-data width in bits
- Y, 104, plaintext/ciphertext width in bits
- MAX, max(K,NW,L,Y) = 128, frame length in load cycles
- CW, $clog2(MAX+1) = 8, bit-counter width

Ports:
- clk  in  1  block clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_i  in  1  serial bit valid; lanes sampled on each clk edge where high
- key_si  in  1  key lane, MSB first
- nonce_si  in  1  nonce lane, MSB first
- ad_si  in  1  associated-data lane, MSB first
- data_si  in  1  PT/CT lane, MSB first
- start_i  in  1  start request (level; rising edge acted on)
- decrypt_i  in  1  mode: 0 = encrypt, 1 = decrypt
- core_ready_i  in  1  ASCON core done indication
- key_o  out  K  assembled key
- nonce_o  out  NW  assembled nonce
- ad_o  out  L  assembled associated data
- data_o  out  Y  assembled PT/CT
- decrypt_o  out  1  mode latched at start
- start_o  out  1  one-cycle start pulse to the core
- armed_o  out  1  frame complete, waiting for start
- busy_o  out  1  core running
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n low): state IDLE, bit counter 0. All outputs 0, including data registers. start_i edge-detect history cleared to 0.
- States: IDLE, LOAD, ARMED, BUSY.
- IDLE, load_i=1: sample bit 0, counter <= 1, go to LOAD, clear err_o.
- LOAD, load_i=1: counter increments. load_i=0 holds all state (gaps allowed).
- Lane capture on a sampled cycle with index i = counter before increment:
  - key shifts left with key_si when i<K.
  - nonce shifts left with nonce_si when i<NW.
  - ad shifts left with ad_si when i<L.
  - data shifts left with data_si when i<Y.
  - Lanes shorter than MAX ignore later bits. After MAX bits, field[W-1] holds the bit sampled at i=0.
- Frame complete: when the MAX-th bit is sampled, go to ARMED. armed_o is high the next cycle. Counter resets to 0.
- Start edge: edge = start_i & ~start_q, where start_q is start_i registered every cycle in every state.
- ARMED, start edge: decrypt_o <= decrypt_i, start_o=1 for exactly one cycle (registered, the cycle after the edge is sampled), go to BUSY. busy_o is high the same cycle start_o is.
- ARMED, load_i=1: ignored, err_o set.
- BUSY, core_ready_i=1: go to IDLE the next cycle, busy_o drops.
  - Register outputs and decrypt_o are held until overwritten by the next frame.
  - core_ready_i is ignored in the cycle start_o is high.
- BUSY, load_i=1 or start edge: ignored, err_o set.
- start edge in IDLE or LOAD: ignored, err_o set. Loading continues.
- start_i held high across frame completion: no edge, so no start; the user must drop and re-raise start_i.
- Simultaneous MAX-th bit and start edge in the same cycle: start treated as early, err_o set, state goes to ARMED.
- Reset mid-LOAD or mid-BUSY: immediate return to IDLE, partial fields discarded (zeroed).
- err_o: sticky; cleared only by reset or the IDLE->LOAD transition.

Optional Feature:
ASCON_LOADER_SYNC_EN:
- Defined: load_i, key_si, nonce_si, ad_si, data_si, start_i and decrypt_i each pass through a 2-flop synchroniser (reset 0) before any logic. All input-to-effect latencies grow by exactly 2 cycles; the lanes stay mutually aligned.
- Undefined: inputs are used directly; the pins are assumed synchronous to clk.

Test Plan:
- Encrypt frame: 128 load cycles with KEY=6d4f8bbf60ec05a07b201d4e5b2119ac, NONCE=05885e606e1271b8d47a74c7b297a318, AD=4153434f4e, PT=6173636f6e2d756e6963617373, decrypt_i=0 -> all four fields equal those values; armed_o=1 one cycle after the 128th bit; err_o=0.
- Start handshake: start_i rising edge in ARMED -> start_o high exactly one cycle, decrypt_o=0, busy_o=1. core_ready_i pulse -> IDLE next cycle, fields unchanged.
- Decrypt frame with CT=18490112f8d5867a830748390b, decrypt_i=1 and 10-cycle gaps in load_i mid-frame -> data_o=CT, decrypt_o=1 after start, no error.
- Protocol errors: start edge at bit 60 -> err_o=1, no start_o, load completes. Next frame's first bit -> err_o=0. Extra load_i in ARMED -> err_o=1, fields unchanged.
- rst_n pulsed low at bit 70 -> all outputs 0 immediately. A fresh full frame then loads correctly.
- With ASCON_LOADER_SYNC_EN defined: repeat the first two scenarios -> armed_o and start_o each appear 2 cycles later than without the macro; field values identical.

Source files
------------

// File: rtl/ascon_serial_loader.sv
// rtl/ascon_serial_loader.sv - serial-to-parallel frame loader and start handshake for the ASCON core
//
// Purpose: deserialises four MSB-first serial lanes into key/nonce/AD/data
// registers over a MAX-cycle frame, then issues a one-cycle start pulse on a
// rising edge of start_i and holds off new frames until the core is ready.
//
// Optional macro: ASCON_LOADER_SYNC_EN puts a 2-flop synchroniser on every
// pin input except core_ready_i (adds exactly 2 cycles to every pin latency).
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   load_i                       serial bit valid
//   key_si/nonce_si/ad_si/data_si serial lanes, MSB first
//   start_i, decrypt_i           start request (edge), mode select
//   core_ready_i                 core done indication
//   key_o/nonce_o/ad_o/data_o    assembled fields
//   decrypt_o                    mode latched at start
//   start_o                      one-cycle start pulse
//   armed_o/busy_o/err_o         frame ready / core running / sticky error
module ascon_serial_loader #(
  parameter int K   = 128,
  parameter int NW  = 128,
  parameter int L   = 40,
  parameter int Y   = 104,
  parameter int MAX = ((K > NW ? K : NW) > (L > Y ? L : Y)) ? (K > NW ? K : NW) : (L > Y ? L : Y),
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          key_si,
  input  logic          nonce_si,
  input  logic          ad_si,
  input  logic          data_si,
  input  logic          start_i,
  input  logic          decrypt_i,
  input  logic          core_ready_i,
  output logic [K-1:0]  key_o,
  output logic [NW-1:0] nonce_o,
  output logic [L-1:0]  ad_o,
  output logic [Y-1:0]  data_o,
  output logic          decrypt_o,
  output logic          start_o,
  output logic          armed_o,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, BUSY} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(MAX - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          load, key_b, nonce_b, ad_b, data_b, start_b, dec_b;
  logic          start_q;
  logic          start_edge;
  logic          sample;
  logic          err_set, err_clr;

`ifdef ASCON_LOADER_SYNC_EN
  logic [6:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {load_i, key_si, nonce_si, ad_si, data_si, start_i, decrypt_i};
      sync2 <= sync1;
    end
  end

  assign {load, key_b, nonce_b, ad_b, data_b, start_b, dec_b} = sync2;
`else
  assign {load, key_b, nonce_b, ad_b, data_b, start_b, dec_b} =
         {load_i, key_si, nonce_si, ad_si, data_si, start_i, decrypt_i};
`endif

  assign start_edge = start_b & ~start_q;
  assign sample     = load & ((state == IDLE) | (state == LOAD));

  // Start edges outside ARMED and bits arriving while ARMED/BUSY are protocol errors.
  assign err_set = (start_edge & (state != ARMED)) |
                   (load & ((state == ARMED) | (state == BUSY)));
  assign err_clr = (state == IDLE) & load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (load) state_nxt = LOAD;
      LOAD:  if (load && cnt == LAST_IDX) state_nxt = ARMED;
      ARMED: if (start_edge) state_nxt = BUSY;
      // core_ready_i is ignored while the start pulse is still on the wire
      BUSY:  if (core_ready_i && !start_o) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    armed_o = (state == ARMED);
    busy_o  = (state == BUSY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      key_o     <= '0;
      nonce_o   <= '0;
      ad_o      <= '0;
      data_o    <= '0;
      decrypt_o <= 1'b0;
      start_o   <= 1'b0;
      err_o     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      start_q <= start_b;
      start_o <= (state == ARMED) & start_edge;
      if ((state == ARMED) && start_edge) decrypt_o <= dec_b;

      if (err_set)      err_o <= 1'b1;
      else if (err_clr) err_o <= 1'b0;

      if (sample) begin
        cnt <= (state == LOAD && cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        // Shorter lanes stop shifting once their width is reached so the
        // first bit ends up in the MSB.
        if (int'(cnt) < K)  key_o   <= {key_o[K-2:0], key_b};
        if (int'(cnt) < NW) nonce_o <= {nonce_o[NW-2:0], nonce_b};
        if (int'(cnt) < L)  ad_o    <= {ad_o[L-2:0], ad_b};
        if (int'(cnt) < Y)  data_o  <= {data_o[Y-2:0], data_b};
      end
    end
  end

endmodule

// File: tb/tb_ascon_serial_loader.sv
// tb/tb_ascon_serial_loader.sv - randomized self-checking bench for ascon_serial_loader
module tb_ascon_serial_loader;

`ifdef ASCON_LOADER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_i = 1'b0, key_si = 1'b0, nonce_si = 1'b0, ad_si = 1'b0, data_si = 1'b0;
  logic         start_i = 1'b0, decrypt_i = 1'b0, core_ready_i = 1'b0;
  logic [127:0] key_o, nonce_o;
  logic [39:0]  ad_o;
  logic [103:0] data_o;
  logic         decrypt_o, start_o, armed_o, busy_o, err_o;

  int total = 0;
  int passed = 0;

  ascon_serial_loader dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .key_si(key_si), .nonce_si(nonce_si),
    .ad_si(ad_si), .data_si(data_si), .start_i(start_i), .decrypt_i(decrypt_i),
    .core_ready_i(core_ready_i), .key_o(key_o), .nonce_o(nonce_o), .ad_o(ad_o),
    .data_o(data_o), .decrypt_o(decrypt_o), .start_o(start_o), .armed_o(armed_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_key"}, key_o, 0);
    check({tag, "_nonce"}, nonce_o, 0);
    check({tag, "_ad"}, {88'b0, ad_o}, 0);
    check({tag, "_data"}, {24'b0, data_o}, 0);
    check({tag, "_flags"}, {123'b0, decrypt_o, start_o, armed_o, busy_o, err_o}, 0);
  endtask

  task automatic check_fields(input string tag, input logic [127:0] k, input logic [127:0] n,
                              input logic [39:0] a, input logic [103:0] d);
    check({tag, "_key"}, key_o, k);
    check({tag, "_nonce"}, nonce_o, n);
    check({tag, "_ad"}, {88'b0, ad_o}, {88'b0, a});
    check({tag, "_data"}, {24'b0, data_o}, {24'b0, d});
  endtask

  // Drives one MAX-bit frame. Lanes beyond their width carry random junk.
  // rst_at >= 0 aborts the frame with a reset pulse at that bit.
  task automatic send_frame(input logic [127:0] k, input logic [127:0] n,
                            input logic [39:0] a, input logic [103:0] d,
                            input int gap_at, input int gap_len,
                            input int start_at, input int rst_at);
    for (int i = 0; i < 128; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          load_i = 1'b0; start_i = 1'b0;
          key_si = 1'($urandom); nonce_si = 1'($urandom);
          ad_si = 1'($urandom); data_si = 1'($urandom);
        end
      end
      @(negedge clk);
      if (i == rst_at) begin
        load_i = 1'b0; start_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_load");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("no_start_in_load", {127'b0, start_o}, 0);
      load_i   = 1'b1;
      key_si   = k[127-i];
      nonce_si = n[127-i];
      ad_si    = (i < 40) ? a[39-i] : 1'($urandom);
      data_si  = (i < 104) ? d[103-i] : 1'($urandom);
      start_i  = (i == start_at);
      if (i == 127) check("armed_early", {127'b0, armed_o}, 0);
    end
    for (int j = 0; j < LAT; j++) begin
      @(negedge clk);
      load_i = 1'b0; start_i = 1'b0;
      check("armed_early", {127'b0, armed_o}, 0);
    end
    @(negedge clk);
    load_i = 1'b0; start_i = 1'b0;
    check("armed_on_time", {127'b0, armed_o}, 1);
  endtask

  task automatic handshake(input logic dec, input logic [127:0] k, input logic [127:0] n,
                           input logic [39:0] a, input logic [103:0] d);
    int wait_cyc;
    @(negedge clk);
    decrypt_i = dec;
    start_i = 1'b1;
    for (int j = 0; j < LAT; j++) begin
      @(negedge clk);
      check("start_early", {127'b0, start_o}, 0);
    end
    @(negedge clk);
    check("start_pulse", {127'b0, start_o}, 1);
    check("busy_with_start", {127'b0, busy_o}, 1);
    check("armed_cleared", {127'b0, armed_o}, 0);
    check("decrypt_latched", {127'b0, decrypt_o}, {127'b0, dec});
    core_ready_i = 1'b1;
    @(negedge clk);
    check("start_one_cycle", {127'b0, start_o}, 0);
    check("ready_ignored_on_start", {127'b0, busy_o}, 1);
    core_ready_i = 1'b0;
    start_i = 1'b0;
    decrypt_i = ~dec;
    wait_cyc = $urandom_range(0, 3);
    for (int j = 0; j < wait_cyc; j++) begin
      @(negedge clk);
      check("busy_hold", {127'b0, busy_o}, 1);
    end
    core_ready_i = 1'b1;
    @(negedge clk);
    core_ready_i = 1'b0;
    check("busy_drop", {127'b0, busy_o}, 0);
    check("idle_not_armed", {127'b0, armed_o}, 0);
    check("decrypt_held", {127'b0, decrypt_o}, {127'b0, dec});
    check_fields("after_done", k, n, a, d);
  endtask

  initial begin
    logic [127:0] k, n;
    logic [39:0]  a;
    logic [103:0] d, ct;
    logic         dec;

    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    k  = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    n  = 128'h05885e606e1271b8d47a74c7b297a318;
    a  = 40'h4153434f4e;
    d  = 104'h6173636f6e2d756e6963617373;
    ct = 104'h18490112f8d5867a830748390b;

    // encrypt frame
    send_frame(k, n, a, d, -1, 0, -1, -1);
    check_fields("enc_frame", k, n, a, d);
    check("enc_err", {127'b0, err_o}, 0);
    handshake(1'b0, k, n, a, d);

    // decrypt frame with a 10-cycle gap mid-frame
    send_frame(k, n, a, ct, 50, 10, -1, -1);
    check_fields("dec_frame", k, n, a, ct);
    check("dec_err", {127'b0, err_o}, 0);
    handshake(1'b1, k, n, a, ct);

    // start edge during load, then extra load in ARMED
    k = {$urandom, $urandom, $urandom, $urandom};
    n = {$urandom, $urandom, $urandom, $urandom};
    a = {8'($urandom), $urandom};
    d = {8'($urandom), $urandom, $urandom, $urandom};
    send_frame(k, n, a, d, -1, 0, 60, -1);
    check("early_start_err", {127'b0, err_o}, 1);
    check_fields("early_start_fields", k, n, a, d);
    @(negedge clk);
    load_i = 1'b1; key_si = 1'b1; nonce_si = 1'b1; ad_si = 1'b1; data_si = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (LAT) @(negedge clk);
    check("armed_load_err", {127'b0, err_o}, 1);
    check("armed_load_state", {127'b0, armed_o}, 1);
    check_fields("armed_load_fields", k, n, a, d);
    handshake(1'b0, k, n, a, d);

    // next frame clears the sticky error
    k = ~k; d = ~d;
    send_frame(k, n, a, d, 20, 3, -1, -1);
    check("err_cleared", {127'b0, err_o}, 0);
    check_fields("after_err_frame", k, n, a, d);
    handshake(1'b1, k, n, a, d);

    // reset mid-frame, then a fresh frame
    send_frame(k, n, a, d, -1, 0, -1, 70);
    repeat (LAT + 1) @(negedge clk);
    check_zero("post_reset");
    k = {$urandom, $urandom, $urandom, $urandom};
    send_frame(k, n, a, d, -1, 0, -1, -1);
    check_fields("fresh_frame", k, n, a, d);
    handshake(1'b0, k, n, a, d);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom, $urandom, $urandom};
      a = {8'($urandom), $urandom};
      d = {8'($urandom), $urandom, $urandom, $urandom};
      dec = 1'($urandom);
      send_frame(k, n, a, d, $urandom_range(1, 127), $urandom_range(0, 5), -1, -1);
      check_fields("rand_frame", k, n, a, d);
      check("rand_err", {127'b0, err_o}, 0);
      handshake(dec, k, n, a, d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
